lc3b_pipe_reg: RTL and testbench

LC3B_PIPE_REG -- requirements
Module: lc3b_pipe_reg

---
 rtl/lc3b_pipe_reg_pkg.sv | 14 +
 rtl/lc3b_pipe_skid_slot.sv | 31 +++
 rtl/lc3b_pipe_reg.sv | 131 +++++++++++++
 tb/tb_lc3b_pipe_reg.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/lc3b_pipe_reg_pkg.sv
// Shared types for the LC-3b pipeline stage register: FSM state encoding
// and the width of the back-pressure stall counter.
package lc3b_types;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } lc3b_pipe_state;

    localparam int STALL_W = 16;
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

endpackage

// File: rtl/lc3b_pipe_skid_slot.sv
// Single-entry skid buffer used by lc3b_pipe_reg; only compiled when
// LC3B_PIPE_REG_SKID_EN is defined. Clear has priority over load.
`ifdef LC3B_PIPE_REG_SKID_EN
module lc3b_pipe_skid_slot #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             vld
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld <= 1'b0;
            q   <= BUBBLE_VAL;
        end else if (clear) begin
            vld <= 1'b0;
            q   <= BUBBLE_VAL;
        end else if (load) begin
            vld <= 1'b1;
            q   <= d;
        end
    end

endmodule
`endif

// File: rtl/lc3b_pipe_reg.sv
// Valid/ready pipeline stage register with saturating stall counter.
// Define LC3B_PIPE_REG_SKID_EN for the skid-buffered, registered-ready build.
module lc3b_pipe_reg
    import lc3b_types::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [STALL_W-1:0] stall_count
);

    function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
        return (v == STALL_MAX) ? v : v + STALL_W'(1);
    endfunction

    logic             vld_p0;
    logic [WIDTH-1:0] data_p0;

    assign out_valid = vld_p0;
    assign out_data  = data_p0;

`ifdef LC3B_PIPE_REG_SKID_EN
    lc3b_pipe_state   state;
    logic             in_ready_r;
    logic             skid_load;
    logic             skid_clear;
    logic             skid_vld;
    logic [WIDTH-1:0] skid_data;

    assign in_ready   = in_ready_r;
    // Skid only captures when main is occupied and downstream is stalled.
    assign skid_load  = !flush && (state == ONE) && in_valid && !out_ready;
    assign skid_clear = flush || ((state == FULL) && out_ready);

    lc3b_pipe_skid_slot #(
        .WIDTH      (WIDTH),
        .BUBBLE_VAL (BUBBLE_VAL)
    ) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (skid_load),
        .clear   (skid_clear),
        .d       (in_data),
        .q       (skid_data),
        .vld     (skid_vld)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= EMPTY;
            in_ready_r <= 1'b1;
            vld_p0     <= 1'b0;
            data_p0    <= BUBBLE_VAL;
        end else if (flush) begin
            state      <= EMPTY;
            in_ready_r <= 1'b1;
            vld_p0     <= 1'b0;
            data_p0    <= BUBBLE_VAL;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_valid) begin
                        state   <= ONE;
                        vld_p0  <= 1'b1;
                        data_p0 <= in_data;
                    end
                end
                ONE: begin
                    if (in_valid && out_ready) begin
                        data_p0 <= in_data;
                    end else if (in_valid) begin
                        state      <= FULL;
                        in_ready_r <= 1'b0;
                    end else if (out_ready) begin
                        state   <= EMPTY;
                        vld_p0  <= 1'b0;
                        data_p0 <= BUBBLE_VAL;
                    end
                end
                FULL: begin
                    if (out_ready && skid_vld) begin
                        state      <= ONE;
                        in_ready_r <= 1'b1;
                        data_p0    <= skid_data;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    in_ready_r <= 1'b1;
                    vld_p0     <= 1'b0;
                    data_p0    <= BUBBLE_VAL;
                end
            endcase
        end
    end
`else
    assign in_ready = !vld_p0 || out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p0  <= 1'b0;
            data_p0 <= BUBBLE_VAL;
        end else if (flush) begin
            vld_p0  <= 1'b0;
            data_p0 <= BUBBLE_VAL;
        end else if (in_ready) begin
            vld_p0  <= in_valid;
            data_p0 <= in_valid ? in_data : BUBBLE_VAL;
        end
    end
`endif

    // Stall counter: back-pressured edges only, flush edges excluded.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (vld_p0 && !out_ready && !flush) begin
            stall_count <= sat_inc(stall_count);
        end
    end

endmodule

// File: tb/tb_lc3b_pipe_reg.sv
// Scoreboard bench for lc3b_pipe_reg; build-specific checks follow
// LC3B_PIPE_REG_SKID_EN.
module tb_lc3b_pipe_reg;

    localparam int          WIDTH  = 32;
    localparam logic [31:0] BUBBLE = 32'hBAD0_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] stall_count;

    logic [31:0] sb[$];
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lc3b_pipe_reg #(
        .WIDTH      (WIDTH),
        .BUBBLE_VAL (BUBBLE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .stall_count (stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: settle, score output/input fires, cross the edge, sample at +1.
    task automatic tick();
        logic [31:0] exp_d;
        #1;
        if (!flush && out_valid && out_ready) begin
            chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                exp_d = sb.pop_front();
                chk("out_data", out_data, exp_d);
            end
        end
        if (flush) sb.delete();
        else if (in_valid && in_ready) sb.push_back(in_data);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n   = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, BUBBLE);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_stall", stall_count, 16'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Stream
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data = 32'h0002_1234; tick(); chk("strm_vld1", out_valid, 1'b1);
        in_data = 32'h0004_5678; tick(); chk("strm_vld2", out_valid, 1'b1);
        in_data = 32'h0006_9ABC; tick(); chk("strm_vld3", out_valid, 1'b1);
        chk("strm_data3", out_data, 32'h0006_9ABC);
        in_valid = 1'b0;
        tick();
        chk("strm_drain_vld", out_valid, 1'b0);
        chk("strm_drain_data", out_data, BUBBLE);

        // Back-pressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hAAAA_0001; tick();
        chk("bp_vld_a", out_valid, 1'b1);
        in_data   = 32'hBBBB_0002; tick();
        chk("bp_in_ready", in_ready, 1'b0);
`ifdef LC3B_PIPE_REG_SKID_EN
        in_valid = 1'b0;
`endif
        repeat (3) tick();
        chk("bp_hold_a", out_data, 32'hAAAA_0001);
        chk("bp_stall", stall_count, 16'd4);
`ifdef LC3B_PIPE_REG_SKID_EN
        out_ready = 1'b1; #1;
        chk("bp_ready_registered", in_ready, 1'b0);
        out_ready = 1'b0; #1;
`else
        out_ready = 1'b1; #1;
        chk("ready_tracks_hi", in_ready, 1'b1);
        out_ready = 1'b0; #1;
        chk("ready_tracks_lo", in_ready, 1'b0);
`endif
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("bp_b_vld", out_valid, 1'b1);
        chk("bp_b_data", out_data, 32'hBBBB_0002);
        tick();
        chk("bp_empty", out_valid, 1'b0);
        chk("bp_stall_after", stall_count, 16'd4);

        // Flush with same-cycle input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hCCCC_0003; tick();
        in_data   = 32'hDDDD_0004; tick();
`ifdef LC3B_PIPE_REG_SKID_EN
        chk("fl_full", in_ready, 1'b0);
`endif
        flush   = 1'b1;
        in_data = 32'hEEEE_0005;
        tick();
        chk("fl_vld", out_valid, 1'b0);
        chk("fl_data", out_data, BUBBLE);
        chk("fl_stall", stall_count, 16'd5);
        chk("fl_in_ready", in_ready, 1'b1);
        flush    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("fl_discard", out_valid, 1'b0);

        // Asynchronous reset mid-transfer
        in_valid = 1'b1;
        in_data  = 32'h1111_0006; tick();
        in_data  = 32'h2222_0007; tick();
        chk("rs_stall_pre", stall_count, 16'd6);
        #2 reset_n = 1'b0;
        #1;
        chk("rs_out_valid", out_valid, 1'b0);
        chk("rs_out_data", out_data, BUBBLE);
        chk("rs_in_ready", in_ready, 1'b1);
        chk("rs_stall", stall_count, 16'd0);
        sb.delete();
        in_valid = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h3333_0008; tick();
        chk("rs_first_vld", out_valid, 1'b1);
        chk("rs_first_data", out_data, 32'h3333_0008);
        in_valid = 1'b0;
        tick();

        // Stall counter saturation
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h4444_0009; tick();
        in_valid  = 1'b0;
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_max", stall_count, 16'hFFFF);
        repeat (5) @(posedge clk);
        #1;
        chk("sat_hold", stall_count, 16'hFFFF);
        chk("sat_vld", out_valid, 1'b1);
        chk("sat_data", out_data, 32'h4444_0009);
        out_ready = 1'b1;
        tick();
        chk("end_vld", out_valid, 1'b0);
        chk("end_sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
